// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 set-2 byte stream to key events with an event FIFO.
// Optional ASCII translation is compiled in with `define KBD_ASCII_EN.
module ps2_kbd_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_extended,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift_held,
    output logic       caps_lock,
    output logic       ev_dropped
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_E0,
        S_GOT_F0,
        S_GOT_E0F0,
        S_PAUSE
    } state_t;

    state_t     r_state;
    logic [2:0] r_skip;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_caps_down;
    logic       r_caps_lock;

    logic       w_emit;
    logic [7:0] w_code;
    logic       w_ext;
    logic       w_brk;

    // Mealy decode: the event is available in the tick cycle so it can be
    // written at the edge ending that cycle.
    always_comb begin
        w_emit = 1'b0;
        w_code = rx_data;
        w_ext  = 1'b0;
        w_brk  = 1'b0;
        if (rx_done_tick) begin
            case (r_state)
                S_IDLE: begin
                    case (rx_data)
                        8'hE0, 8'hF0, 8'hE1,
                        8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'h00, 8'hFF: w_emit = 1'b0;
                        default: w_emit = 1'b1;
                    endcase
                end
                S_GOT_E0: begin
                    w_ext  = 1'b1;
                    w_emit = (rx_data != 8'hF0) && (rx_data != 8'h12) && (rx_data != 8'h59);
                end
                S_GOT_F0: begin
                    w_brk  = 1'b1;
                    w_emit = 1'b1;
                end
                S_GOT_E0F0: begin
                    w_ext  = 1'b1;
                    w_brk  = 1'b1;
                    w_emit = (rx_data != 8'h12) && (rx_data != 8'h59);
                end
                S_PAUSE: begin
                    w_code = 8'h77;
                    w_ext  = 1'b1;
                    w_emit = (r_skip == 3'd1);
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_skip  <= 3'd0;
        end else if (rx_done_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        r_state <= S_GOT_E0;
                    end else if (rx_data == 8'hF0) begin
                        r_state <= S_GOT_F0;
                    end else if (rx_data == 8'hE1) begin
                        r_state <= S_PAUSE;
                        r_skip  <= 3'd7;
                    end
                end
                S_GOT_E0:   r_state <= (rx_data == 8'hF0) ? S_GOT_E0F0 : S_IDLE;
                S_GOT_F0:   r_state <= S_IDLE;
                S_GOT_E0F0: r_state <= S_IDLE;
                S_PAUSE: begin
                    r_skip <= r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps_down <= 1'b0;
            r_caps_lock <= 1'b0;
        end else if (w_emit && !w_ext) begin
            case (w_code)
                8'h12: r_lshift <= !w_brk;
                8'h59: r_rshift <= !w_brk;
                8'h58: begin
                    if (w_brk) begin
                        r_caps_down <= 1'b0;
                    end else if (!r_caps_down) begin
                        r_caps_lock <= !r_caps_lock;
                        r_caps_down <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shift_held = r_lshift | r_rshift;
    assign caps_lock  = r_caps_lock;

`ifdef KBD_ASCII_EN
    function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic shift,
                                           input logic caps);
        logic [7:0] letter;
        logic [7:0] dig;
        logic [7:0] sym;
        logic [7:0] res;
        letter = 8'h00;
        dig    = 8'h00;
        sym    = 8'h00;
        res    = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h45: begin dig = "0"; sym = ")"; end
            8'h16: begin dig = "1"; sym = "!"; end
            8'h1E: begin dig = "2"; sym = "@"; end
            8'h26: begin dig = "3"; sym = "#"; end
            8'h25: begin dig = "4"; sym = "$"; end
            8'h2E: begin dig = "5"; sym = "%"; end
            8'h36: begin dig = "6"; sym = "^"; end
            8'h3D: begin dig = "7"; sym = "&"; end
            8'h3E: begin dig = "8"; sym = "*"; end
            8'h46: begin dig = "9"; sym = "("; end
            8'h29: res = 8'h20;
            8'h5A: res = 8'h0D;
            8'h66: res = 8'h08;
            default: res = 8'h00;
        endcase
        if (letter != 8'h00) begin
            res = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else if (dig != 8'h00) begin
            res = shift ? sym : dig;
        end
        return res;
    endfunction

    logic [7:0] w_ascii;
    assign w_ascii = (w_brk || w_ext) ? 8'h00 : f_ascii(w_code, shift_held, r_caps_lock);
`endif

    logic [7:0]    r_mem_code [FIFO_DEPTH];
    logic          r_mem_ext  [FIFO_DEPTH];
    logic          r_mem_brk  [FIFO_DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic [7:0]    r_head_code;
    logic          r_head_ext;
    logic          r_head_brk;
    logic          r_dropped;

    logic          w_do_pop;
    logic          w_do_push;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_fill;
    logic [CW-1:0] w_count_next;
    logic          w_head_new;

    assign w_do_pop     = ev_ready && (r_count != '0);
    assign w_do_push    = w_emit && ((r_count != CW'(FIFO_DEPTH)) || w_do_pop);
    assign w_rd_next    = r_rd + AW'(w_do_pop);
    assign w_fill       = r_count - CW'(w_do_pop);
    assign w_count_next = w_fill + CW'(w_do_push);
    // The pushed entry becomes the head only when nothing older remains.
    assign w_head_new   = w_do_push && (w_fill == '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_code[r_wr] <= w_code;
            r_mem_ext[r_wr]  <= w_ext;
            r_mem_brk[r_wr]  <= w_brk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_head_code <= 8'h00;
            r_head_ext  <= 1'b0;
            r_head_brk  <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_rd      <= w_rd_next;
            r_wr      <= r_wr + AW'(w_do_push);
            r_count   <= w_count_next;
            r_valid   <= (w_count_next != '0);
            r_dropped <= w_emit && !w_do_push;
            if (w_head_new) begin
                r_head_code <= w_code;
                r_head_ext  <= w_ext;
                r_head_brk  <= w_brk;
            end else if (w_do_pop) begin
                r_head_code <= r_mem_code[w_rd_next];
                r_head_ext  <= r_mem_ext[w_rd_next];
                r_head_brk  <= r_mem_brk[w_rd_next];
            end
        end
    end

`ifdef KBD_ASCII_EN
    logic [7:0] r_mem_ascii [FIFO_DEPTH];
    logic [7:0] r_head_ascii;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_ascii[r_wr] <= w_ascii;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_ascii <= 8'h00;
        end else if (w_head_new) begin
            r_head_ascii <= w_ascii;
        end else if (w_do_pop) begin
            r_head_ascii <= r_mem_ascii[w_rd_next];
        end
    end

    assign ev_ascii = r_head_ascii;
`else
    assign ev_ascii = 8'h00;
`endif

    assign ev_valid    = r_valid;
    assign ev_code     = r_head_code;
    assign ev_extended = r_head_ext;
    assign ev_break    = r_head_brk;
    assign ev_dropped  = r_dropped;
endmodule
